// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed seven-segment bus, waits for each scanned position to settle,
// and decodes the pattern back into per-position {enable, hex digit, dot}.
module seg_scan_decoder #(
    parameter int NUM_DIGITS     = 8,
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEL_ACTIVE_LOW = 1'b1,
    localparam int IDXW          = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   sel_in,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dots,
    output logic [NUM_DIGITS-1:0]   enables,
    output logic [NUM_DIGITS-1:0]   invalid,
    output logic                    capture_valid,
    output logic [IDXW-1:0]         capture_idx,
    output logic                    frame_done
);

    localparam int                  CNTW    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNTW-1:0]     CNT_MAX = CNTW'(STABLE_CYCLES);
    localparam logic [CNTW-1:0]     CNT_ONE = CNTW'(1);
    localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURED
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNTW-1:0]         r_cnt;
    logic [CNTW-1:0]         w_cnt_nxt;
    logic                    w_capture;

    logic [7:0]              r_seg_p0;
    logic [7:0]              r_seg_p1;
    logic [7:0]              r_seg_p2;
    logic [NUM_DIGITS-1:0]   r_sel_p0;
    logic [NUM_DIGITS-1:0]   r_sel_p1;
    logic [NUM_DIGITS-1:0]   r_sel_p2;

    logic [NUM_DIGITS-1:0]   w_sel_norm;
    logic                    w_onehot;
    logic                    w_same;
    logic [IDXW-1:0]         w_idx;
    logic [5:0]              w_dec;
    logic [NUM_DIGITS-1:0]   w_seen_set;
    logic                    w_frame_complete;

    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_dots;
    logic [NUM_DIGITS-1:0]   r_enables;
    logic [NUM_DIGITS-1:0]   r_invalid;
    logic [NUM_DIGITS-1:0]   r_seen;
    logic                    r_cap_valid;
    logic [IDXW-1:0]         r_cap_idx;
    logic                    r_frame_done;

    // Returns {invalid, enable, digit[3:0]} for a g..a segment pattern.
    function automatic logic [5:0] decode_seg(input logic [6:0] pat);
        case (pat)
            7'h3F:   return 6'h10;
            7'h06:   return 6'h11;
            7'h5B:   return 6'h12;
            7'h4F:   return 6'h13;
            7'h66:   return 6'h14;
            7'h6D:   return 6'h15;
            7'h7D:   return 6'h16;
            7'h07:   return 6'h17;
            7'h7F:   return 6'h18;
            7'h6F:   return 6'h19;
            7'h77:   return 6'h1A;
            7'h7C:   return 6'h1B;
            7'h39:   return 6'h1C;
            7'h5E:   return 6'h1D;
            7'h79:   return 6'h1E;
            7'h71:   return 6'h1F;
            7'h00:   return 6'h00;
            default: return 6'h30;
        endcase
    endfunction

    function automatic logic [IDXW-1:0] onehot_index(input logic [NUM_DIGITS-1:0] sel);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) idx = IDXW'(i);
        end
        return idx;
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    assign w_sel_norm       = SEL_ACTIVE_LOW ? ~r_sel_p1 : r_sel_p1;
    assign w_onehot         = (w_sel_norm != '0) && ((w_sel_norm & (w_sel_norm - SEL_ONE)) == '0);
    assign w_same           = (w_sel_norm == r_sel_p2) && (r_seg_p1 == r_seg_p2);
    assign w_idx            = onehot_index(w_sel_norm);
    assign w_dec            = decode_seg(r_seg_p1[6:0]);
    assign w_seen_set       = r_seen | w_sel_norm;
    assign w_frame_complete = &w_seen_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_onehot) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                if (!w_onehot) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (!w_same) begin
                    w_cnt_nxt   = CNT_ONE;
                end else begin
                    w_cnt_nxt   = sat_inc(r_cnt);
                end
            end
            ST_CAPTURED: begin
                if (!w_same) begin
                    if (w_onehot) begin
                        w_state_nxt = ST_SETTLE;
                        w_cnt_nxt   = CNT_ONE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        // Reaching the threshold on this edge is the capture itself, so the
        // one-cycle-stable case (threshold of 1) captures straight from IDLE.
        if (w_state_nxt == ST_SETTLE && w_cnt_nxt == CNT_MAX) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_CAPTURED;
        end
        if (clear) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_capture   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_p0     <= '0;
            r_seg_p1     <= '0;
            r_seg_p2     <= '0;
            r_sel_p0     <= '0;
            r_sel_p1     <= '0;
            r_sel_p2     <= '0;
            r_digits     <= '0;
            r_dots       <= '0;
            r_enables    <= '0;
            r_invalid    <= '0;
            r_seen       <= '0;
            r_cap_valid  <= 1'b0;
            r_cap_idx    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            // p0 -> p1: two-flop synchronizer on the raw pins
            r_seg_p0     <= seg_in;
            r_sel_p0     <= sel_in;
            r_seg_p1     <= r_seg_p0;
            r_sel_p1     <= r_sel_p0;
            // p1 -> p2: previous normalized sample for the stability compare
            r_seg_p2     <= r_seg_p1;
            r_sel_p2     <= w_sel_norm;
            r_cap_valid  <= w_capture;
            r_frame_done <= w_capture && w_frame_complete;
            if (clear) begin
                r_digits  <= '0;
                r_dots    <= '0;
                r_enables <= '0;
                r_invalid <= '0;
                r_seen    <= '0;
            end else if (w_capture) begin
                r_digits[{w_idx, 2'b00} +: 4] <= w_dec[3:0];
                r_dots[w_idx]    <= r_seg_p1[7];
                r_enables[w_idx] <= w_dec[4];
                r_invalid[w_idx] <= w_dec[5];
                r_cap_idx        <= w_idx;
                r_seen           <= w_frame_complete ? '0 : w_seen_set;
            end
        end
    end

    assign digits        = r_digits;
    assign dots          = r_dots;
    assign enables       = r_enables;
    assign invalid       = r_invalid;
    assign capture_valid = r_cap_valid;
    assign capture_idx   = r_cap_idx;
    assign frame_done    = r_frame_done;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: decode table vectors, directed corner sequences and a
// randomized scan checked every cycle against a run-length reference model.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  seg_in = 8'h00;
    logic [7:0]  sel_in = 8'hFF;
    logic        clear = 1'b0;
    logic [31:0] digits;
    logic [7:0]  dots;
    logic [7:0]  enables;
    logic [7:0]  invalid;
    logic        capture_valid;
    logic [2:0]  capture_idx;
    logic        frame_done;

    seg_scan_decoder #(
        .NUM_DIGITS    (8),
        .STABLE_CYCLES (4),
        .SEL_ACTIVE_LOW(1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg_in       (seg_in),
        .sel_in       (sel_in),
        .clear        (clear),
        .digits       (digits),
        .dots         (dots),
        .enables      (enables),
        .invalid      (invalid),
        .capture_valid(capture_valid),
        .capture_idx  (capture_idx),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cap(input string name, input int maxc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!capture_valid && n < maxc);
        chk(name, capture_valid, 1);
    endtask

    // Reference model: digit glyphs 0..F
    logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [15:0] mq1, mq2, mlast, ms;
    int          mrun, mpos;
    logic [31:0] mdig;
    logic [7:0]  mdots, men, minv, mseen;
    logic        mcv, mfd, mfound;
    logic [2:0]  midx;
    logic [3:0]  mval;

    task model_reset();
        mq1 = 0; mq2 = 0; mlast = 0; mrun = 0;
        mdig = 0; mdots = 0; men = 0; minv = 0; mseen = 0;
        mcv = 0; mfd = 0; midx = 0;
    endtask

    // The decoder sees the pins two edges late; it captures once a one-hot sample
    // has been seen on STABLE_CYCLES consecutive edges since it last changed.
    task model_step();
        ms  = {~mq2[15:8], mq2[7:0]};
        mcv = 0;
        mfd = 0;
        if (clear) begin
            mdig = 0; mdots = 0; men = 0; minv = 0; mseen = 0;
            mrun = 0;
        end else begin
            if ($countones(ms[15:8]) != 1) mrun = 0;
            else if (mrun == 0 || ms != mlast) mrun = 1;
            else mrun = mrun + 1;
            if (mrun == 4) begin
                mpos = 0;
                for (int b = 0; b < 8; b++) if (ms[8+b]) mpos = b;
                mfound = 0;
                mval = 0;
                for (int v = 0; v < 16; v++) if (pat[v] == ms[6:0]) begin mfound = 1; mval = 4'(v); end
                mdots[mpos] = ms[7];
                mdig[mpos*4 +: 4] = mval;
                if (mfound) begin men[mpos] = 1; minv[mpos] = 0; end
                else if (ms[6:0] == 7'h00) begin men[mpos] = 0; minv[mpos] = 0; end
                else begin men[mpos] = 1; minv[mpos] = 1; end
                mcv  = 1;
                midx = 3'(mpos);
                mseen[mpos] = 1;
                if (mseen == 8'hFF) begin mfd = 1; mseen = 0; end
            end
        end
        mlast = ms;
        mq2 = mq1;
        mq1 = {sel_in, seg_in};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    always @(negedge clk) begin
        chk("model", {3'b0, digits, dots, enables, invalid, capture_valid, capture_idx, frame_done},
            {3'b0, mdig, mdots, men, minv, mcv, midx, mfd});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] sel;
        logic [7:0] seg;
        int         idx;
        logic [3:0] dig;
        logic       en;
        logic       inv;
        logic       dot;
        logic       fd;
    } vec_t;

    vec_t        tbl [18];
    int          p, rp, rr, rh, cvn;
    logic [7:0]  rsel;

    initial begin
        tbl[0]  = '{8'hFE, 8'h3F, 0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{8'hFD, 8'h06, 1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{8'hFB, 8'h5B, 2, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{8'hF7, 8'hCF, 3, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{8'hEF, 8'h66, 4, 4'h4, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{8'hDF, 8'h6D, 5, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{8'hBF, 8'h7D, 6, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{8'h7F, 8'h07, 7, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{8'hFE, 8'h7F, 0, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{8'hFD, 8'hEF, 1, 4'h9, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{8'hFB, 8'h49, 2, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{8'hFB, 8'h00, 2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{8'hF7, 8'h77, 3, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{8'hEF, 8'h7C, 4, 4'hB, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{8'hDF, 8'h39, 5, 4'hC, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[15] = '{8'hBF, 8'h5E, 6, 4'hD, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{8'h7F, 8'h79, 7, 4'hE, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[17] = '{8'hFE, 8'hF1, 0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0};

        // reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {digits, dots, enables, invalid, capture_valid, capture_idx, frame_done}, 64'h0);
        rst_n = 1'b1;
        tick();

        // first-capture latency: pins change just after edge e, capture edge is e+6
        sel_in = 8'hFE;
        seg_in = 8'h5B;
        cvn = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (capture_valid) cvn++;
        end
        chk("lat_early", cvn, 0);
        tick();
        chk("lat_pulse", capture_valid, 1);
        chk("lat_idx", capture_idx, 0);
        chk("lat_digit", digits[3:0], 4'h2);
        chk("lat_en", enables[0], 1);
        chk("lat_dot", dots[0], 0);
        chk("lat_inv", invalid[0], 0);
        tick();
        chk("lat_single", capture_valid, 0);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_arrays", {digits, dots, enables, invalid}, 64'h0);

        // decode table and frame tracking
        for (int i = 0; i < 18; i++) begin
            sel_in = tbl[i].sel;
            seg_in = tbl[i].seg;
            wait_cap($sformatf("tbl%0d_cap", i), 20);
            p = tbl[i].idx;
            chk($sformatf("tbl%0d_idx", i), capture_idx, p);
            chk($sformatf("tbl%0d_digit", i), digits[p*4 +: 4], tbl[i].dig);
            chk($sformatf("tbl%0d_en", i), enables[p], tbl[i].en);
            chk($sformatf("tbl%0d_inv", i), invalid[p], tbl[i].inv);
            chk($sformatf("tbl%0d_dot", i), dots[p], tbl[i].dot);
            chk($sformatf("tbl%0d_frame", i), frame_done, tbl[i].fd);
            if (i == 7) begin
                chk("scan_digits", digits, 32'h76543210);
                chk("scan_dots", dots, 8'h08);
                chk("scan_en", enables, 8'hFF);
                chk("scan_inv", invalid, 8'h00);
            end
        end

        // non-one-hot selects never capture and leave the arrays alone
        cvn = 0;
        sel_in = 8'hFC;
        for (int i = 0; i < 20; i++) begin tick(); if (capture_valid || frame_done) cvn++; end
        sel_in = 8'hFF;
        for (int i = 0; i < 20; i++) begin tick(); if (capture_valid || frame_done) cvn++; end
        chk("nonhot_pulses", cvn, 0);
        chk("nonhot_hold", {digits, dots, enables, invalid}, {32'hEDCBA09F, 8'h03, 8'hFB, 8'h00});

        // glitching dot bit: runs of 2 never reach the threshold
        sel_in = 8'hFD;
        cvn = 0;
        for (int i = 0; i < 8; i++) begin
            seg_in = 8'h06;
            tick(); if (capture_valid) cvn++;
            tick(); if (capture_valid) cvn++;
            seg_in = 8'h86;
            tick(); if (capture_valid) cvn++;
            tick(); if (capture_valid) cvn++;
        end
        chk("glitch_nocap", cvn, 0);
        wait_cap("glitch_cap", 20);
        chk("glitch_idx", capture_idx, 1);
        chk("glitch_digit", digits[7:4], 4'h1);
        chk("glitch_dot", dots[1], 1);

        // clear landing on the capture edge drops the capture
        sel_in = 8'hDF;
        seg_in = 8'h66;
        repeat (5) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clrcap_valid", capture_valid, 0);
        chk("clrcap_frame", frame_done, 0);
        chk("clrcap_arrays", {digits, dots, enables, invalid}, 64'h0);
        chk("clrcap_idx", capture_idx, 1);
        repeat (8) tick();

        // asynchronous reset while settling
        sel_in = 8'hBF;
        seg_in = 8'h06;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid", {digits, dots, enables, invalid, capture_valid, capture_idx, frame_done}, 64'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        wait_cap("rst_recover", 20);
        chk("rst_rec_idx", capture_idx, 6);
        chk("rst_rec_arrays", {digits, dots, enables, invalid}, {32'h01000000, 8'h00, 8'h40, 8'h00});

        // randomized scan against the model
        for (int it = 0; it < 300; it++) begin
            rp = $urandom_range(0, 7);
            rr = $urandom_range(0, 9);
            if (rr < 8) rsel = 8'h01 << rp;
            else rsel = 8'($urandom);
            sel_in = ~rsel;
            rr = $urandom_range(0, 9);
            if (rr < 6) seg_in = {1'($urandom_range(0, 1)), pat[$urandom_range(0, 15)]};
            else if (rr < 8) seg_in = {1'($urandom_range(0, 1)), 7'h00};
            else seg_in = 8'($urandom);
            rh = $urandom_range(1, 8);
            for (int h = 0; h < rh; h++) begin
                clear = ($urandom_range(0, 29) == 0);
                tick();
                clear = 1'b0;
            end
        end
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receive-side counterpart of the seven-segment digit decoder. Snoops a multiplexed 8-bit segment bus and its digit-select lines, waits for each scanned position to settle, and converts the segment pattern back into {enable, hex digit, dot}, stored per position. Used on the test/loopback board to check display drivers, and to read displays driven by external logic.

Parameters:
NUM_DIGITS, 8, number of scanned positions (2..16); derived IDXW = clog2(NUM_DIGITS).
STABLE_CYCLES, 4, consecutive identical synchronized samples required before capture (1..255).
SEL_ACTIVE_LOW, 1, 1: sel_in is active-low; 0: active-high.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
seg_in  in  8  segment bus; bit7 = dot, bits6:0 = g..a, active-high.
sel_in  in  NUM_DIGITS  digit select; bit i selects position i; polarity set by SEL_ACTIVE_LOW.
clear  in  1  synchronous clear of all captured state.
digits  out  4*NUM_DIGITS  captured hex value; position i is at [4i+3:4i].
dots  out  NUM_DIGITS  captured dot per position.
enables  out  NUM_DIGITS  1 = position lit (non-blank pattern).
invalid  out  NUM_DIGITS  1 = last capture was a non-table pattern.
capture_valid  out  1  one-cycle pulse on each capture.
capture_idx  out  IDXW  position of the latest capture; valid with capture_valid, held otherwise.
frame_done  out  1  one-cycle pulse when every position has been captured since the last frame_done or clear.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; synchronizers, sample registers, stability counter and seen mask are 0; FSM goes to IDLE.
- Synchronization: seg_in and sel_in each pass through a 2-flop synchronizer. sel is normalized to active-high. The sample S = {sel_norm, seg} is registered every cycle as S_prev.
- FSM:
  - IDLE: sel_norm is not exactly one-hot (zero or multiple bits set); the counter is held at 0. When sel_norm becomes one-hot, go to SETTLE with counter = 1.
  - SETTLE: if S == S_prev, the counter increments. If S differs and sel_norm is one-hot, restart with counter = 1. If sel_norm is not one-hot, go to IDLE. When the counter reaches STABLE_CYCLES, capture on that edge and go to CAPTURED.
  - CAPTURED: no recapture while S is unchanged. If S changes, go to SETTLE with counter = 1 if one-hot, otherwise go to IDLE.
- Latency: pins are stable from clock edge k onward. The first synchronized sample is at k+2. capture_valid is high in the cycle after edge k+1+STABLE_CYCLES, and the arrays update on that same edge.
- Decode of seg[6:0] (hex), written to the selected position:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F: digit = value, enable = 1, invalid = 0.
  - 00: enable = 0, digit = 0, invalid = 0 (blank).
  - Any other pattern: enable = 1, digit = 0, invalid = 1.
  - dots[i] = seg[7] in every case. Positions that are not selected are untouched.
- Frame tracking:
  - Each capture sets seen[idx].
  - On the edge where seen becomes all ones: frame_done pulses for the next cycle, and seen clears to 0 on that same edge (the completing capture is not counted into the next frame).
  - Recapturing an already-seen position does not advance the frame.
- clear (synchronous, highest priority):
  - Next edge: digits, dots, enables, invalid and seen go to 0, and the FSM goes to IDLE.
  - A capture due in the same cycle is dropped: no capture_valid and no frame_done.
  - capture_idx is held.
- Counter width is clog2(STABLE_CYCLES+1). It saturates and never wraps.
- rst_n asserted mid-capture: immediate asynchronous return to the reset state. No partial update is visible.

Test Plan:
- NUM_DIGITS=8, active-low sel=8'hFE, seg=8'h5B held for 10 cycles → one capture_valid pulse 6 cycles after the first sampling edge, with capture_idx=0, digits[3:0]=2, enables[0]=1, dots[0]=0, invalid[0]=0.
- Scan positions 0..7 with patterns for 0..7 (3F,06,5B,4F,66,6D,7D,07) plus a dot on position 3, 20 cycles each → digits=32'h76543210, dots=8'h08, enables=8'hFF, a single frame_done after the position-7 capture, and seen reset afterwards.
- Glitch: sel=FD with seg toggling between 06 and 86 every 2 cycles, STABLE_CYCLES=4 → no capture; then seg held at 86 → capture with digits[7:4]=1, dots[1]=1.
- Invalid and blank: sel=FB, seg=0x49 → invalid[2]=1, enables[2]=1, digits=0. Then seg=0x00 → enables[2]=0, invalid[2]=0, capture_valid pulses again.
- Non-one-hot sel (8'hFC, then 8'hFF) held for 20 cycles → no capture, FSM stays in IDLE, outputs unchanged.
- clear asserted in the capture cycle → capture dropped and all arrays are 0. Separately, rst_n pulled low mid-SETTLE → all outputs 0 immediately, and a fresh stable input captures normally after release.
